// File: rtl/i2c_slave_regmap_if.sv
// Byte-level event bus between the I2C slave byte engine and the register map.
// master modport: the byte engine (drives START/STOP/byte events, receives
//                 ACK decisions and transmit bytes).
// slave modport : the register map.
// Signals:
//   s_start    START / repeated START with address match (1-cycle pulse)
//   s_rw       R/W bit, valid with s_start (1 = read)
//   s_stop     STOP seen (1-cycle pulse)
//   s_wr_valid received byte present on s_wr_data (1-cycle pulse)
//   s_wr_data  received byte
//   s_wr_resp  response pulse, one clock after s_wr_valid
//   s_wr_ack   valid with s_wr_resp: 1 = ACK, 0 = NACK
//   s_rd_req   engine requests next transmit byte (1-cycle pulse)
//   s_rd_valid transmit byte valid, one clock after s_rd_req
//   s_rd_data  transmit byte, held until the next s_rd_valid
interface i2c_slave_regmap_if;
  logic       s_start;
  logic       s_rw;
  logic       s_stop;
  logic       s_wr_valid;
  logic [7:0] s_wr_data;
  logic       s_wr_resp;
  logic       s_wr_ack;
  logic       s_rd_req;
  logic       s_rd_valid;
  logic [7:0] s_rd_data;

  modport master (
    output s_start, s_rw, s_stop, s_wr_valid, s_wr_data, s_rd_req,
    input  s_wr_resp, s_wr_ack, s_rd_valid, s_rd_data
  );

  modport slave (
    input  s_start, s_rw, s_stop, s_wr_valid, s_wr_data, s_rd_req,
    output s_wr_resp, s_wr_ack, s_rd_valid, s_rd_data
  );
endinterface

// File: rtl/i2c_slave_regmap.sv
// I2C slave register map. Tracks the register pointer (with 8-bit wrapping
// auto-increment), holds RO_BASE writable 8-bit registers and exposes a
// read-only window of live status bytes at RO_BASE..REG_COUNT-1.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   bus          byte-event bus from the slave byte engine (slave side)
//   ro_in        live status, byte k appears at address RO_BASE+k
//   rw_out       flat copy of the writable registers, byte k = address k
//   reg_wr_stb   1-cycle pulse per accepted register write
//   reg_wr_addr  address of that write
//   reg_wr_data  data of that write
module i2c_slave_regmap #(
  parameter int         REG_COUNT = 16,
  parameter int         RO_BASE   = 8,
  parameter logic [7:0] RST_VAL   = 8'h00,
  parameter logic [7:0] OOR_VAL   = 8'hFF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  i2c_slave_regmap_if.slave                 bus,
  input  logic [8*(REG_COUNT-RO_BASE)-1:0]  ro_in,
  output logic [8*RO_BASE-1:0]              rw_out,
  output logic                              reg_wr_stb,
  output logic [7:0]                        reg_wr_addr,
  output logic [7:0]                        reg_wr_data
);

  typedef enum logic [1:0] {IDLE, PTR, WDATA, RDATA} state_e;

  localparam logic [8:0] RO_BASE_W = 9'(RO_BASE);

  state_e     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] regs_q [RO_BASE];
  logic [7:0] regs_d [RO_BASE];
  logic       wr_resp_q, wr_resp_d;
  logic       wr_ack_q, wr_ack_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       stb_q, stb_d;
  logic [7:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;

  logic       ptr_is_rw;
  logic [7:0] rd_lookup;

  assign ptr_is_rw = ({1'b0, ptr_q} < RO_BASE_W);

  // Byte addressed by the current pointer: writable bank, status window,
  // or the out-of-range filler.
  always_comb begin
    rd_lookup = OOR_VAL;
    for (int i = 0; i < RO_BASE; i++) begin
      if (ptr_q == 8'(i)) rd_lookup = regs_q[i];
    end
    for (int k = 0; k < REG_COUNT - RO_BASE; k++) begin
      if (ptr_q == 8'(RO_BASE + k)) rd_lookup = ro_in[8*k +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    regs_d     = regs_q;
    wr_resp_d  = 1'b0;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    stb_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    // START/STOP pre-empt any byte event in the same cycle; the byte is
    // dropped without a response pulse.
    if (bus.s_start) begin
      state_d = bus.s_rw ? RDATA : PTR;
    end else if (bus.s_stop) begin
      state_d = IDLE;
    end else begin
      if (bus.s_wr_valid) begin
        wr_resp_d = 1'b1;
        case (state_q)
          PTR: begin
            ptr_d    = bus.s_wr_data;
            wr_ack_d = 1'b1;
            state_d  = WDATA;
          end
          WDATA: begin
            if (ptr_is_rw) begin
              for (int i = 0; i < RO_BASE; i++) begin
                if (ptr_q == 8'(i)) regs_d[i] = bus.s_wr_data;
              end
              stb_d    = 1'b1;
              waddr_d  = ptr_q;
              wdata_d  = bus.s_wr_data;
              wr_ack_d = 1'b1;
            end
            // Pointer advances even over read-only addresses so a burst
            // stays aligned with the master's view of the address space.
            ptr_d = ptr_q + 8'd1;
          end
          default: ; // IDLE / RDATA: NACK, nothing else changes
        endcase
      end
      if (bus.s_rd_req) begin
        rd_valid_d = 1'b1;
        if (state_q == RDATA) begin
          rd_data_d = rd_lookup;
          ptr_d     = ptr_q + 8'd1;
        end else begin
          rd_data_d = OOR_VAL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 8'h00;
      for (int i = 0; i < RO_BASE; i++) regs_q[i] <= RST_VAL;
      wr_resp_q  <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      stb_q      <= 1'b0;
      waddr_q    <= 8'h00;
      wdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      regs_q     <= regs_d;
      wr_resp_q  <= wr_resp_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      stb_q      <= stb_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  generate
    for (genvar gi = 0; gi < RO_BASE; gi++) begin : g_rw_out
      assign rw_out[8*gi +: 8] = regs_q[gi];
    end
  endgenerate

  assign bus.s_wr_resp  = wr_resp_q;
  assign bus.s_wr_ack   = wr_ack_q;
  assign bus.s_rd_valid = rd_valid_q;
  assign bus.s_rd_data  = rd_data_q;
  assign reg_wr_stb     = stb_q;
  assign reg_wr_addr    = waddr_q;
  assign reg_wr_data    = wdata_q;

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Directed bench for i2c_slave_regmap: a transaction-level model predicts
// every output for the cycle after each stimulus cycle; a negedge process
// compares all outputs every cycle, and literal checks pin key results.
module tb_i2c_slave_regmap;
  localparam int REG_COUNT = 16;
  localparam int RO_BASE   = 8;
  localparam logic [7:0] RST_VAL = 8'h00;
  localparam logic [7:0] OOR_VAL = 8'hFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8*(REG_COUNT-RO_BASE)-1:0] ro_in = '0;
  logic [8*RO_BASE-1:0] rw_out;
  logic reg_wr_stb;
  logic [7:0] reg_wr_addr, reg_wr_data;

  i2c_slave_regmap_if bus_if();

  i2c_slave_regmap #(.REG_COUNT(REG_COUNT), .RO_BASE(RO_BASE),
                     .RST_VAL(RST_VAL), .OOR_VAL(OOR_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave), .ro_in(ro_in),
    .rw_out(rw_out), .reg_wr_stb(reg_wr_stb),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- model: transaction view of the register map ----
  typedef enum int {M_IDLE, M_PTR, M_WDATA, M_RDATA} mode_t;
  mode_t      m_mode;
  logic [7:0] m_ptr;
  logic [7:0] m_mem [RO_BASE];
  // predicted outputs after the next edge
  logic n_resp, n_ack, n_rdv, n_stb;
  logic [7:0] n_rdata, n_waddr, n_wdata;
  // expectations in force for the current cycle
  logic e_resp, e_ack, e_rdv, e_stb;
  logic [7:0] e_rdata, e_waddr, e_wdata;
  logic [7:0] e_mem [RO_BASE];

  function automatic logic [7:0] spec_read(input logic [7:0] a);
    if (int'(a) < RO_BASE) return m_mem[a[2:0]];
    if (int'(a) < REG_COUNT) return ro_in[8*(int'(a)-RO_BASE) +: 8];
    return OOR_VAL;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ptr = 8'h00;
    for (int i = 0; i < RO_BASE; i++) begin m_mem[i] = RST_VAL; e_mem[i] = RST_VAL; end
    n_rdata = 8'h00; n_waddr = 8'h00; n_wdata = 8'h00;
    e_resp = 0; e_ack = 0; e_rdv = 0; e_stb = 0;
    e_rdata = 8'h00; e_waddr = 8'h00; e_wdata = 8'h00;
  endtask

  task automatic model_step();
    mode_t old_mode = m_mode;
    n_resp = 0; n_ack = 0; n_rdv = 0; n_stb = 0;
    if (bus_if.s_start) m_mode = bus_if.s_rw ? M_RDATA : M_PTR;
    else if (bus_if.s_stop) m_mode = M_IDLE;
    else begin
      if (bus_if.s_wr_valid) begin
        n_resp = 1;
        if (old_mode == M_PTR) begin
          m_ptr = bus_if.s_wr_data; n_ack = 1; m_mode = M_WDATA;
        end else if (old_mode == M_WDATA) begin
          if (int'(m_ptr) < RO_BASE) begin
            m_mem[m_ptr[2:0]] = bus_if.s_wr_data;
            n_stb = 1; n_ack = 1; n_waddr = m_ptr; n_wdata = bus_if.s_wr_data;
          end
          m_ptr = m_ptr + 8'd1;
        end
      end
      if (bus_if.s_rd_req) begin
        n_rdv = 1;
        if (old_mode == M_RDATA) begin
          n_rdata = spec_read(m_ptr); m_ptr = m_ptr + 8'd1;
        end else n_rdata = OOR_VAL;
      end
    end
  endtask

  // One stimulus cycle: inputs already set; predict, clock, release pulses.
  task automatic cycle();
    model_step();
    @(posedge clk);
    e_resp = n_resp; e_ack = n_ack; e_rdv = n_rdv; e_stb = n_stb;
    e_rdata = n_rdata; e_waddr = n_waddr; e_wdata = n_wdata;
    for (int i = 0; i < RO_BASE; i++) e_mem[i] = m_mem[i];
    #1;
    bus_if.s_start = 0; bus_if.s_rw = 0; bus_if.s_stop = 0;
    bus_if.s_wr_valid = 0; bus_if.s_rd_req = 0;
  endtask

  task automatic do_start(input logic rw); bus_if.s_start = 1; bus_if.s_rw = rw; cycle(); endtask
  task automatic do_stop(); bus_if.s_stop = 1; cycle(); endtask
  task automatic do_wr(input logic [7:0] b); bus_if.s_wr_valid = 1; bus_if.s_wr_data = b; cycle(); endtask
  task automatic do_rd(); bus_if.s_rd_req = 1; cycle(); endtask
  task automatic do_idle(); cycle(); endtask

  // Continuous comparison against the model on every cycle.
  always @(negedge clk) begin
    chk("wr_resp", bus_if.s_wr_resp, e_resp);
    chk("wr_ack", bus_if.s_wr_ack, e_ack);
    chk("rd_valid", bus_if.s_rd_valid, e_rdv);
    chk("rd_data", bus_if.s_rd_data, e_rdata);
    chk("wr_stb", reg_wr_stb, e_stb);
    chk("wr_addr", reg_wr_addr, e_waddr);
    chk("wr_data", reg_wr_data, e_wdata);
    for (int i = 0; i < RO_BASE; i++)
      chk($sformatf("rw_out[%0d]", i), rw_out[8*i +: 8], e_mem[i]);
  end

  initial begin
    bus_if.s_start = 0; bus_if.s_rw = 0; bus_if.s_stop = 0;
    bus_if.s_wr_valid = 0; bus_if.s_wr_data = 8'h00; bus_if.s_rd_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", bus_if.s_rd_data, 8'h00);
    chk("reset_rw_out", rw_out, '0);
    rst_n = 1;
    $display("txn reset released");

    // Out-of-range pointer read
    do_start(0); do_wr(8'h8F);
    chk("t1_ptr_ack", bus_if.s_wr_ack, 1'b1);
    do_start(1); do_rd();
    chk("t1_oor_read", bus_if.s_rd_data, 8'hFF);
    do_stop();
    $display("txn t1 ptr=8F read=%h", bus_if.s_rd_data);

    // Two single-byte writes
    do_start(0); do_wr(8'h03); do_wr(8'h7B);
    chk("t2_stb", reg_wr_stb, 1'b1);
    chk("t2_addr", reg_wr_addr, 8'h03);
    chk("t2_ack", bus_if.s_wr_ack, 1'b1);
    do_stop();
    do_start(0); do_wr(8'h02); do_wr(8'h3A);
    chk("t2_addr2", reg_wr_addr, 8'h02);
    do_stop();
    chk("t2_rw3", rw_out[31:24], 8'h7B);
    chk("t2_rw2", rw_out[23:16], 8'h3A);
    $display("txn t2 rw_out=%h", rw_out);

    // Word write then repeated-START read
    do_start(0); do_wr(8'h00); do_wr(8'hCB); do_wr(8'h04); do_stop();
    do_start(0); do_wr(8'h00); do_start(1);
    do_rd(); chk("t3_rd0", bus_if.s_rd_data, 8'hCB);
    do_rd(); chk("t3_rd1", bus_if.s_rd_data, 8'h04);
    do_stop();
    do_start(1); do_rd(); chk("t3_ptr02", bus_if.s_rd_data, 8'h3A);
    do_stop();
    $display("txn t3 word CB04 read back");

    // Write into read-only window
    ro_in[7:0] = 8'h5A; ro_in[15:8] = 8'hA5;
    do_start(0); do_wr(8'h08); do_wr(8'h11);
    chk("t4_nack", bus_if.s_wr_ack, 1'b0);
    chk("t4_resp", bus_if.s_wr_resp, 1'b1);
    chk("t4_nostb", reg_wr_stb, 1'b0);
    do_stop();
    do_start(1); do_rd(); chk("t4_ro1", bus_if.s_rd_data, 8'hA5);
    do_stop();
    $display("txn t4 ro write NACK, read=%h", bus_if.s_rd_data);

    // Pointer wrap FF -> 00
    do_start(0); do_wr(8'hFF); do_start(1);
    do_rd(); chk("t5_ff", bus_if.s_rd_data, 8'hFF);
    do_rd(); chk("t5_wrap", bus_if.s_rd_data, 8'hCB);
    do_stop();
    $display("txn t5 wrap read=%h", bus_if.s_rd_data);

    // Byte coincident with STOP is dropped; then a stray byte in IDLE
    do_start(0); do_wr(8'h05);
    bus_if.s_stop = 1; bus_if.s_wr_valid = 1; bus_if.s_wr_data = 8'h99; cycle();
    chk("e1_no_resp", bus_if.s_wr_resp, 1'b0);
    do_wr(8'h77);
    chk("e1_idle_resp", bus_if.s_wr_resp, 1'b1);
    chk("e1_idle_nack", bus_if.s_wr_ack, 1'b0);
    chk("e1_rw5", rw_out[47:40], 8'h00);
    // START and STOP together: START wins
    bus_if.s_start = 1; bus_if.s_stop = 1; bus_if.s_rw = 0; cycle();
    do_wr(8'h06); chk("e2_ptr_ack", bus_if.s_wr_ack, 1'b1);
    do_wr(8'h66); chk("e2_addr", reg_wr_addr, 8'h06);
    do_stop();
    // Read request outside RDATA
    do_rd(); chk("e3_rd_idle", bus_if.s_rd_data, 8'hFF);
    $display("txn edge cases done");

    // Reset in the middle of a write burst
    do_start(0); do_wr(8'h01); do_wr(8'h55); do_idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rw_out", rw_out, '0);
    chk("rst_stb", reg_wr_stb, 1'b0);
    rst_n = 1;
    do_start(1); do_rd(); chk("rst_ptr0", bus_if.s_rd_data, RST_VAL);
    do_stop(); do_idle(); do_idle();
    $display("txn mid-write reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
